// File: rtl/rca_pkg.sv
// Shared constants, state encodings and sizing helpers for the
// multi-precision adder sequencer.
package rca_pkg;

    localparam int ADD_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int word_count(input int width);
        return width / ADD_W;
    endfunction

endpackage

// File: rtl/RCA64b.sv
// 64-bit ripple-carry adder shared by the sequencer.
// Purely combinational; its ripple delay sets the sequencer fmax.
module RCA64b (
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic        C_in,
    output logic [63:0] sum,
    output logic        C_out
);

    logic c;

    always_comb begin
        c   = C_in;
        sum = '0;
        for (int i = 0; i < 64; i++) begin
            sum[i] = A[i] ^ B[i] ^ c;
            c      = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
        end
        C_out = c;
    end

endmodule

// File: rtl/rca_mp_sequencer.sv
// Multi-precision add/subtract sequencer: streams WIDTH-bit operands
// through one external 64-bit adder, one word per cycle, LSW first.
module rca_mp_sequencer
    import rca_pkg::*;
#(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic             in_C_in,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_C_out,
    output logic             busy,
    output logic [63:0]      add_A,
    output logic [63:0]      add_B,
    output logic             add_C_in,
    input  logic [63:0]      add_sum,
    input  logic             add_C_out
);

    localparam int NWORDS = word_count(WIDTH);
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    if ((WIDTH % ADD_W) != 0 || WIDTH < ADD_W) begin : g_bad_width
        $error("rca_mp_sequencer: WIDTH must be a positive multiple of 64");
    end

    state_t state_q, state_d;

    logic [NWORDS-1:0][ADD_W-1:0] a_q;
    logic [NWORDS-1:0][ADD_W-1:0] b_q;
    logic [NWORDS-1:0][ADD_W-1:0] res_q;
    logic [IDX_W-1:0]             idx_q;
    logic                         c0_q;
    logic                         carry_q;
    logic                         accept;
    logic                         last;

    assign accept = in_valid && in_ready;
    assign last   = (idx_q == IDX_W'(NWORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        add_A     = '0;
        add_B     = '0;
        add_C_in  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                add_A    = a_q[idx_q];
                add_B    = b_q[idx_q];
                add_C_in = (idx_q == '0) ? c0_q : carry_q;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Subtraction is folded into the operand latch: B is inverted and
    // the first-word carry forced to 1, so RUN only ever adds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            c0_q    <= 1'b0;
            carry_q <= 1'b0;
        end else if (accept) begin
            a_q   <= in_A;
            b_q   <= in_sub ? ~in_B : in_B;
            c0_q  <= in_sub | in_C_in;
            idx_q <= '0;
        end else if (state_q == RUN) begin
            res_q[idx_q] <= add_sum;
            carry_q      <= add_C_out;
            if (!last) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign out_sum   = res_q;
    assign out_C_out = carry_q;

endmodule

// File: tb/tb_rca_mp_sequencer.sv
// Randomised self-checking bench for rca_mp_sequencer driving RCA64b,
// compared against a plain WIDTH-bit arithmetic reference.
module tb_rca_mp_sequencer;

    localparam int WIDTH = 256;
    localparam int NW    = WIDTH / 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] in_A, in_B;
    logic             in_C_in, in_sub;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_C_out, busy;
    logic [63:0]      add_A, add_B, add_sum;
    logic             add_C_in, add_C_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rca_mp_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B),
        .in_C_in(in_C_in), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_C_out(out_C_out),
        .busy(busy),
        .add_A(add_A), .add_B(add_B), .add_C_in(add_C_in),
        .add_sum(add_sum), .add_C_out(add_C_out)
    );

    RCA64b u_rca (
        .A(add_A), .B(add_B), .C_in(add_C_in),
        .sum(add_sum), .C_out(add_C_out)
    );

    task automatic check(input string tag,
                         input logic [WIDTH:0] got,
                         input logic [WIDTH:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH:0] ref_op(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic cin,
                                              input logic sub);
        logic [WIDTH-1:0] d;
        if (sub) begin
            d = a - b;
            return {(a >= b), d};
        end
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    endfunction

    // Called at a negedge with the DUT idle; returns there after handoff.
    task automatic do_op(input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b,
                         input logic cin,
                         input logic sub,
                         input int hold,
                         output logic [WIDTH-1:0] s,
                         output logic co,
                         output int lat,
                         output logic [NW-1:0] cseen);
        logic [WIDTH:0] exp;
        int k;
        exp   = ref_op(a, b, cin, sub);
        cseen = '0;
        s     = '0;
        co    = 1'b0;
        check("in_ready_idle", in_ready, 1);
        in_A     = a;
        in_B     = b;
        in_C_in  = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_A     = {8{$urandom}};
        in_B     = {8{$urandom}};
        k = 0;
        while (!out_valid && k < 20) begin
            if (busy && k < NW) cseen[k] = add_C_in;
            @(negedge clk);
            k++;
        end
        lat = k;
        if (!out_valid) begin
            check("timeout", 0, 1);
            return;
        end
        s  = out_sum;
        co = out_C_out;
        check("sum", s, exp[WIDTH-1:0]);
        check("c_out", co, exp[WIDTH]);
        for (int h = 0; h < hold; h++) begin
            in_valid = (h == 3);
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_ready", in_ready, 0);
            check("bp_sum", out_sum, s);
            check("bp_cout", out_C_out, co);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_busy", busy, 0);
    endtask

    logic [WIDTH-1:0] s, ra, rb, ones;
    logic             co;
    int               lat, mode;
    logic [NW-1:0]    cs;

    initial begin
        ones      = '1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_A      = '0;
        in_B      = '0;
        in_C_in   = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", out_sum, 0);
        check("rst_cout", out_C_out, 0);
        check("rst_add", {add_A, add_B, add_C_in}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(ones, 1, 0, 0, 0, s, co, lat, cs);
        check("t1_lat", lat, NW);
        check("t1_cseen", cs, 4'b1110);

        do_op(0, 0, 1, 0, 0, s, co, lat, cs);
        check("t2_cseen", cs, 4'b0001);

        do_op(7, 5, 1, 1, 0, s, co, lat, cs);
        do_op(5, 7, 0, 1, 0, s, co, lat, cs);
        check("t3_sum", s, ones - 1);

        do_op({192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 1, 0, 0, 0, s, co, lat, cs);
        check("t4_cseen", cs, 4'b0010);

        do_op({8{$urandom}}, {8{$urandom}}, 1, 0, 10, s, co, lat, cs);
        check("t5_ready", in_ready, 1);

        in_A     = ones;
        in_B     = ones;
        in_sub   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6_valid", out_valid, 0);
        check("t6_ready", in_ready, 1);
        check("t6_busy0", busy, 0);
        check("t6_add", {add_A, add_B, add_C_in}, 0);
        check("t6_sum0", out_sum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(3, 4, 0, 0, 0, s, co, lat, cs);

        for (int n = 0; n < 10000; n++) begin
            ra   = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
            rb   = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
            mode = $urandom_range(0, 4);
            case (mode)
                1: rb = ra;
                2: ra = ones;
                3: rb = ~ra;
                4: rb = rb >> $urandom_range(0, 255);
                default: ;
            endcase
            do_op(ra, rb, 1'($urandom), 1'($urandom), 0, s, co, lat, cs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
